// File: rtl/sextium_syscall_unit.sv
// rtl/sextium_syscall_unit.sv - Sextium III SYSCALL responder (HALT/READ/WRITE over word streams)
module sextium_syscall_unit #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 runio,
    input  logic [WIDTH-1:0]     acc,
    input  logic [WIDTH-1:0]     dr,
    output logic                 iobusy,
    output logic [WIDTH-1:0]     io_result,
    output logic                 halted,
    output logic                 err,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_HALT,
        S_BUSY
    } state_t;

    localparam logic [WIDTH-1:0]     CODE_HALT  = WIDTH'(0);
    localparam logic [WIDTH-1:0]     CODE_READ  = WIDTH'(1);
    localparam logic [WIDTH-1:0]     CODE_WRITE = WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic                 iobusy_q, iobusy_d;
    logic [WIDTH-1:0]     io_result_q, io_result_d;
    logic                 halted_q, halted_d;
    logic                 err_q, err_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            iobusy_q    <= 1'b0;
            io_result_q <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            iobusy_q    <= iobusy_d;
            io_result_q <= io_result_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // iobusy rises on the dispatch edge so the controller's wait state sees it next cycle.
    always_comb begin
        state_d     = state_q;
        iobusy_d    = iobusy_q;
        io_result_d = io_result_q;
        halted_d    = halted_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        case (state_q)
            S_IDLE: begin
                if (runio) begin
                    iobusy_d = 1'b1;
                    if (acc == CODE_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (acc == CODE_READ) begin
                        state_d = S_READ;
                    end else if (acc == CODE_WRITE) begin
                        state_d     = S_WRITE;
                        out_valid_d = 1'b1;
                        out_data_d  = dr;
                    end else begin
                        state_d = S_BUSY;
                        err_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (in_valid) begin
                    io_result_d = in_data;
                    rd_count_d  = rd_count_q + CNT_ONE;
                    iobusy_d    = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_WRITE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    wr_count_d  = wr_count_q + CNT_ONE;
                    iobusy_d    = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_HALT: begin
                iobusy_d    = 1'b1;
                out_valid_d = 1'b0;
            end
            S_BUSY: begin
                iobusy_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                iobusy_d    = 1'b0;
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_READ);
    assign iobusy    = iobusy_q;
    assign io_result = io_result_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sextium_syscall_unit.sv
// tb/tb_sextium_syscall_unit.sv - randomized self-checking bench for sextium_syscall_unit
module tb_sextium_syscall_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        runio;
    logic [15:0] acc, dr, in_data;
    logic        in_valid, out_ready;

    logic        iobusy, halted, err, in_ready, out_valid;
    logic [15:0] io_result, out_data, rd_count, wr_count;

    logic        d2_iobusy, d2_halted, d2_err, d2_in_ready, d2_out_valid;
    logic [15:0] d2_io_result, d2_out_data;
    logic [1:0]  d2_rd_count, d2_wr_count;

    int tests = 0;
    int failures = 0;

    int          exp_rd, exp_wr;
    logic [15:0] exp_result;
    logic        exp_err;

    always #5 clock = ~clock;

    sextium_syscall_unit #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .runio(runio), .acc(acc), .dr(dr),
        .iobusy(iobusy), .io_result(io_result), .halted(halted), .err(err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    sextium_syscall_unit #(.WIDTH(16), .CNT_WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .runio(runio), .acc(acc), .dr(dr),
        .iobusy(d2_iobusy), .io_result(d2_io_result), .halted(d2_halted), .err(d2_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(d2_in_ready),
        .out_valid(d2_out_valid), .out_data(d2_out_data), .out_ready(out_ready),
        .rd_count(d2_rd_count), .wr_count(d2_wr_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        exp_rd = 0;
        exp_wr = 0;
        exp_result = 16'h0;
        exp_err = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] data, input int stall, input string nm);
        runio = 1'b1; acc = 16'd1; dr = 16'($urandom); in_valid = 1'b0;
        tick();
        runio = 1'($urandom); acc = 16'($urandom);
        for (int i = 0; i < stall; i++) begin
            tests++;
            if ({iobusy, in_ready, out_valid} !== 3'b110) begin
                failures++;
                $display("FAIL %s read_wait[%0d] busy/ready/ovalid=%b expected 110", nm, i, {iobusy, in_ready, out_valid});
            end
            in_data = 16'($urandom);
            tick();
        end
        in_valid = 1'b1; in_data = data;
        tests++;
        if ({iobusy, in_ready} !== 2'b11 || io_result !== exp_result) begin
            failures++;
            $display("FAIL %s read_accept busy/ready=%b result=%h expected 11 %h", nm, {iobusy, in_ready}, io_result, exp_result);
        end
        tick();
        runio = 1'b0; in_valid = 1'b0;
        exp_rd++; exp_result = data;
        tests++;
        if ({iobusy, in_ready} !== 2'b00 || io_result !== exp_result || err !== exp_err) begin
            failures++;
            $display("FAIL %s read_done busy/ready=%b result=%h err=%b expected 00 %h %b", nm, {iobusy, in_ready}, io_result, err, exp_result, exp_err);
        end
        tests++;
        if (rd_count !== 16'(exp_rd) || d2_rd_count !== 2'(exp_rd)) begin
            failures++;
            $display("FAIL %s rd_count=%0d/%0d expected %0d/%0d", nm, rd_count, d2_rd_count, 16'(exp_rd), 2'(exp_rd));
        end
    endtask

    task automatic do_write(input logic [15:0] data, input int stall, input string nm);
        runio = 1'b1; acc = 16'd2; dr = data; out_ready = 1'b0;
        tick();
        runio = 1'($urandom); acc = 16'($urandom); dr = 16'($urandom);
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) out_ready = 1'b1;
            tests++;
            if ({iobusy, out_valid, in_ready} !== 3'b110 || out_data !== data) begin
                failures++;
                $display("FAIL %s write_wait[%0d] busy/ovalid/iready=%b data=%h expected 110 %h", nm, i, {iobusy, out_valid, in_ready}, out_data, data);
            end
            tick();
        end
        out_ready = 1'b0; runio = 1'b0;
        exp_wr++;
        tests++;
        if ({iobusy, out_valid} !== 2'b00 || io_result !== exp_result) begin
            failures++;
            $display("FAIL %s write_done busy/ovalid=%b result=%h expected 00 %h", nm, {iobusy, out_valid}, io_result, exp_result);
        end
        tests++;
        if (wr_count !== 16'(exp_wr) || d2_wr_count !== 2'(exp_wr)) begin
            failures++;
            $display("FAIL %s wr_count=%0d/%0d expected %0d/%0d", nm, wr_count, d2_wr_count, 16'(exp_wr), 2'(exp_wr));
        end
    endtask

    task automatic do_illegal(input logic [15:0] code, input string nm);
        runio = 1'b1; acc = code;
        tick();
        runio = 1'($urandom);
        exp_err = 1'b1;
        tests++;
        if ({iobusy, err, in_ready, out_valid, halted} !== 5'b11000) begin
            failures++;
            $display("FAIL %s illegal_pulse busy/err/iready/ovalid/halted=%b expected 11000 code=%h", nm, {iobusy, err, in_ready, out_valid, halted}, code);
        end
        tick();
        runio = 1'b0;
        tests++;
        if (iobusy !== 1'b0 || err !== 1'b1 || io_result !== exp_result) begin
            failures++;
            $display("FAIL %s illegal_end busy=%b err=%b result=%h expected 0 1 %h", nm, iobusy, err, io_result, exp_result);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; runio = 1'b1; acc = 16'd1; dr = 16'h0;
        in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        tick(); tick();
        model_reset();
        tests++;
        if ({iobusy, in_ready, out_valid, halted, err} !== 5'b0 || io_result !== 16'h0 ||
            out_data !== 16'h0 || rd_count !== 16'h0 || wr_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_hold flags=%b result=%h odata=%h rd=%0d wr=%0d expected all zero",
                     {iobusy, in_ready, out_valid, halted, err}, io_result, out_data, rd_count, wr_count);
        end
        tests++;
        if ({d2_iobusy, d2_in_ready, d2_out_valid, d2_halted, d2_err} !== 5'b0 || d2_io_result !== 16'h0 ||
            d2_out_data !== 16'h0 || d2_rd_count !== 2'd0 || d2_wr_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold_narrow flags=%b rd=%0d wr=%0d expected zero",
                     {d2_iobusy, d2_in_ready, d2_out_valid, d2_halted, d2_err}, d2_rd_count, d2_wr_count);
        end
        runio = 1'b0; reset = 1'b1;
        tick();
        tests++;
        if ({iobusy, in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release busy/ready=%b expected 00", {iobusy, in_ready});
        end
    endtask

    task automatic test_write();
        do_write(16'h1234, 3, "write");
    endtask

    task automatic test_read_stall();
        do_read(16'hBEEF, 5, "read_stall");
    endtask

    task automatic test_back_to_back();
        do_read(16'h5A5A, 1, "b2b_read");
        do_write(16'hC0DE, 0, "b2b_write");
        do_write(16'h0F0F, 2, "b2b_write2");
        do_read(16'h1111, 0, "b2b_read2");
    endtask

    task automatic test_illegal();
        do_illegal(16'd7, "illegal7");
        do_illegal(16'd3, "illegal3");
        do_illegal(16'hFFFF, "illegal_max");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            int gap;
            kind = int'($urandom_range(0, 5));
            if (kind <= 1)
                do_read(16'($urandom), int'($urandom_range(0, 4)), "rand_read");
            else if (kind <= 3)
                do_write(16'($urandom), int'($urandom_range(0, 4)), "rand_write");
            else if (kind == 4)
                do_illegal(16'($urandom_range(3, 16'hFFFF)), "rand_illegal");
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'($urandom); out_ready = 1'($urandom);
                tick();
                in_valid = 1'b0; out_ready = 1'b0;
                tests++;
                if ({iobusy, in_ready, out_valid} !== 3'b000 || rd_count !== 16'(exp_rd) ||
                    wr_count !== 16'(exp_wr) || io_result !== exp_result) begin
                    failures++;
                    $display("FAIL rand_idle flags=%b rd=%0d wr=%0d result=%h expected 000 %0d %0d %h",
                             {iobusy, in_ready, out_valid}, rd_count, wr_count, io_result, exp_rd, exp_wr, exp_result);
                end
            end
        end
    endtask

    task automatic test_halt();
        runio = 1'b1; acc = 16'd0;
        tick();
        runio = 1'b0;
        tests++;
        if ({halted, iobusy, in_ready, out_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL halt_enter halted/busy/iready/ovalid=%b expected 1100", {halted, iobusy, in_ready, out_valid});
        end
        for (int i = 0; i < 8; i++) begin
            runio = 1'($urandom); acc = 16'($urandom_range(0, 3));
            in_valid = 1'($urandom); in_data = 16'($urandom); out_ready = 1'($urandom);
            tick();
            tests++;
            if ({halted, iobusy, in_ready, out_valid} !== 4'b1100 || rd_count !== 16'(exp_rd) ||
                wr_count !== 16'(exp_wr) || io_result !== exp_result) begin
                failures++;
                $display("FAIL halt_hold[%0d] flags=%b rd=%0d wr=%0d result=%h expected 1100 %0d %0d %h",
                         i, {halted, iobusy, in_ready, out_valid}, rd_count, wr_count, io_result, exp_rd, exp_wr, exp_result);
            end
        end
        runio = 1'b0; in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tests++;
        if ({halted, iobusy, err, out_valid} !== 4'b0000 || rd_count !== 16'h0 || wr_count !== 16'h0 || io_result !== 16'h0) begin
            failures++;
            $display("FAIL halt_reset flags=%b rd=%0d wr=%0d result=%h expected zero",
                     {halted, iobusy, err, out_valid}, rd_count, wr_count, io_result);
        end
    endtask

    task automatic test_reset_mid_write();
        runio = 1'b1; acc = 16'd2; dr = 16'hA5A5; out_ready = 1'b0;
        tick();
        runio = 1'b0; out_ready = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1; out_ready = 1'b0;
        model_reset();
        tests++;
        if ({out_valid, iobusy} !== 2'b00 || wr_count !== 16'h0 || d2_wr_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_write ovalid/busy=%b wr=%0d/%0d expected 00 0/0", {out_valid, iobusy}, wr_count, d2_wr_count);
        end
        tick();
        tests++;
        if ({out_valid, iobusy, in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_write_idle flags=%b expected 000", {out_valid, iobusy, in_ready});
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 4; i++)
            do_read(16'($urandom), int'($urandom_range(0, 2)), "wrap_read");
        tests++;
        if (d2_rd_count !== 2'd0 || rd_count !== 16'd4) begin
            failures++;
            $display("FAIL counter_wrap rd=%0d narrow=%0d expected 4 0", rd_count, d2_rd_count);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_back_to_back();
        test_illegal();
        test_random();
        test_halt();
        test_reset_mid_write();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
